// File: rtl/xspi_rd_cal.sv
`default_nettype none
// ============================================================================
// Module   : xspi_rd_cal
// Purpose  : xSPI read-capture calibration. Sweeps a common delay tap,
//            issues a DLP read at each tap, tracks per-lane passing windows
//            and reports the centre of the widest window for each lane.
// Revision : 1.0 - initial release
// ============================================================================
module xspi_rd_cal #(
  parameter int         DQ_WIDTH       = 8,
  parameter int         TAP_WIDTH      = 5,
  parameter int         TAP_MAX        = 31,
  parameter logic [7:0] DLP_PATTERN    = 8'h34,
  parameter int         DLP_REPEAT     = 2,
  parameter int         SETTLE_CYCLES  = 4,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         MIN_WINDOW     = 3,
  parameter int         DEFAULT_TAP    = 0
) (
  input  logic                          mem_clk,
  input  logic                          mem_rst_n,
  input  logic                          cal_start_i,
  input  logic                          cal_abort_i,
  output logic                          rd_req_o,
  input  logic                          rd_ack_i,
  input  logic                          samp_valid_i,
  input  logic [DQ_WIDTH-1:0]           samp_dq_i,
  output logic [TAP_WIDTH-1:0]          sweep_tap_o,
  output logic                          cal_busy_o,
  output logic                          cal_done_o,
  output logic [DQ_WIDTH*TAP_WIDTH-1:0] lane_tap_o,
  output logic [DQ_WIDTH-1:0]           lane_fail_o,
  output logic                          timeout_o
);

  localparam int SAMPLES = 8 * DLP_REPEAT;
  localparam int SCW     = $clog2(SAMPLES);
  localparam int STW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TOW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SCW-1:0]       SAMP_LAST   = SCW'(SAMPLES - 1);
  localparam logic [STW-1:0]       SETTLE_LAST = STW'(SETTLE_CYCLES - 1);
  localparam logic [TOW-1:0]       TO_LAST     = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [TAP_WIDTH-1:0] TAP_LAST    = TAP_WIDTH'(TAP_MAX);
  localparam logic [TAP_WIDTH-1:0] DEF_TAP     = TAP_WIDTH'(DEFAULT_TAP);
  localparam logic [TAP_WIDTH:0]   MIN_LEN     = (TAP_WIDTH + 1)'(MIN_WINDOW);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_REQ     = 3'd2,
    S_CAPTURE = 3'd3,
    S_EVAL    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                 state;
  logic [TAP_WIDTH-1:0]   tap;
  logic [STW-1:0]         settle_cnt;
  logic [SCW-1:0]         samp_cnt;
  logic [TOW-1:0]         to_cnt;
  logic [DQ_WIDTH-1:0]    lane_err;
  logic                   rd_req;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  logic [DQ_WIDTH-1:0]    lane_fail;
  logic [DQ_WIDTH*TAP_WIDTH-1:0] lane_tap;

  // Per-lane run trackers; lengths are one bit wider so a full sweep fits.
  logic [TAP_WIDTH-1:0]   cur_start  [DQ_WIDTH];
  logic [TAP_WIDTH:0]     cur_len    [DQ_WIDTH];
  logic [TAP_WIDTH-1:0]   best_start [DQ_WIDTH];
  logic [TAP_WIDTH:0]     best_len   [DQ_WIDTH];

  logic [TAP_WIDTH-1:0]   nxt_start  [DQ_WIDTH];
  logic [TAP_WIDTH:0]     nxt_len    [DQ_WIDTH];
  logic [TAP_WIDTH:0]     centre_sum [DQ_WIDTH];
  logic [DQ_WIDTH-1:0]    take_best;
  logic [DQ_WIDTH-1:0]    lane_good;
  logic                   exp_bit;

  // Pattern is compared MSB first, repeating every 8 samples.
  assign exp_bit = DLP_PATTERN[3'd7 - samp_cnt[2:0]];

  assign rd_req_o    = rd_req;
  assign sweep_tap_o = tap;
  assign cal_busy_o  = busy;
  assign cal_done_o  = done;
  assign lane_tap_o  = lane_tap;
  assign lane_fail_o = lane_fail;
  assign timeout_o   = timeout;

  // Next run per lane for this tap, best-window update and window centre.
  always_comb begin
    take_best = '0;
    lane_good = '0;
    for (int k = 0; k < DQ_WIDTH; k++) begin
      nxt_start[k] = cur_start[k];
      nxt_len[k]   = '0;
      if (!lane_err[k]) begin
        nxt_start[k] = (cur_len[k] == '0) ? tap : cur_start[k];
        nxt_len[k]   = cur_len[k] + 1'b1;
      end
      take_best[k]  = nxt_len[k] > best_len[k];
      centre_sum[k] = {1'b0, best_start[k]} + ((best_len[k] - 1'b1) >> 1);
      lane_good[k]  = best_len[k] >= MIN_LEN;
    end
  end

  // Calibration sequencer with registered outputs.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state      <= S_IDLE;
      tap        <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      to_cnt     <= '0;
      lane_err   <= '0;
      rd_req     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      lane_fail  <= '0;
      for (int k = 0; k < DQ_WIDTH; k++) begin
        cur_start[k]  <= '0;
        cur_len[k]    <= '0;
        best_start[k] <= '0;
        best_len[k]   <= '0;
        lane_tap[k*TAP_WIDTH +: TAP_WIDTH] <= DEF_TAP;
      end
    end else begin
      done <= 1'b0;
      if (cal_abort_i && (state != S_IDLE)) begin
        // Abort leaves previous results untouched and issues no done pulse.
        state  <= S_IDLE;
        rd_req <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cal_start_i && !cal_abort_i) begin
              tap        <= '0;
              settle_cnt <= '0;
              timeout    <= 1'b0;
              busy       <= 1'b1;
              for (int k = 0; k < DQ_WIDTH; k++) begin
                cur_start[k]  <= '0;
                cur_len[k]    <= '0;
                best_start[k] <= '0;
                best_len[k]   <= '0;
              end
              state <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              rd_req     <= 1'b1;
              state      <= S_REQ;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_REQ: begin
            if (rd_ack_i) begin
              rd_req   <= 1'b0;
              samp_cnt <= '0;
              to_cnt   <= '0;
              lane_err <= '0;
              state    <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (samp_valid_i) begin
              lane_err <= lane_err | (samp_dq_i ^ {DQ_WIDTH{exp_bit}});
              samp_cnt <= samp_cnt + 1'b1;
            end
            if (samp_valid_i && (samp_cnt == SAMP_LAST)) begin
              state <= S_EVAL;
            end else if (to_cnt == TO_LAST) begin
              // A stalled burst makes the whole tap fail on every lane.
              lane_err <= '1;
              timeout  <= 1'b1;
              state    <= S_EVAL;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_EVAL: begin
            for (int k = 0; k < DQ_WIDTH; k++) begin
              cur_start[k] <= nxt_start[k];
              cur_len[k]   <= nxt_len[k];
              if (take_best[k]) begin
                best_start[k] <= nxt_start[k];
                best_len[k]   <= nxt_len[k];
              end
            end
            if (tap == TAP_LAST) begin
              state <= S_DONE;
            end else begin
              tap   <= tap + 1'b1;
              state <= S_SETTLE;
            end
          end
          S_DONE: begin
            for (int k = 0; k < DQ_WIDTH; k++) begin
              lane_tap[k*TAP_WIDTH +: TAP_WIDTH] <=
                lane_good[k] ? centre_sum[k][TAP_WIDTH-1:0] : DEF_TAP;
              lane_fail[k] <= !lane_good[k];
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xspi_rd_cal.sv
`default_nettype none
// ============================================================================
// Module   : tb_xspi_rd_cal
// Purpose  : Scoreboard bench for xspi_rd_cal. A PHY model answers read
//            requests with DLP bursts; expected results are queued at start
//            and checked by a monitor on each cal_done_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xspi_rd_cal;

  logic        mem_clk = 1'b0;
  logic        mem_rst_n;
  logic        cal_start_i;
  logic        cal_abort_i;
  logic        rd_req_o;
  logic        rd_ack_i;
  logic        samp_valid_i;
  logic [7:0]  samp_dq_i;
  logic [4:0]  sweep_tap_o;
  logic        cal_busy_o;
  logic        cal_done_o;
  logic [39:0] lane_tap_o;
  logic [7:0]  lane_fail_o;
  logic        timeout_o;

  xspi_rd_cal dut (
    .mem_clk      (mem_clk),
    .mem_rst_n    (mem_rst_n),
    .cal_start_i  (cal_start_i),
    .cal_abort_i  (cal_abort_i),
    .rd_req_o     (rd_req_o),
    .rd_ack_i     (rd_ack_i),
    .samp_valid_i (samp_valid_i),
    .samp_dq_i    (samp_dq_i),
    .sweep_tap_o  (sweep_tap_o),
    .cal_busy_o   (cal_busy_o),
    .cal_done_o   (cal_done_o),
    .lane_tap_o   (lane_tap_o),
    .lane_fail_o  (lane_fail_o),
    .timeout_o    (timeout_o)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct packed {
    logic [39:0] taps;
    logic [7:0]  fail;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          ack_cnt = 0;
  int          to_tap = -1;
  logic        in_burst = 1'b0;
  logic [31:0] pass_map [8];
  logic [7:0]  pattern = 8'h34;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [39:0] rep(input int t);
    logic [39:0] r;
    for (int k = 0; k < 8; k++) r[k*5 +: 5] = 5'(t);
    return r;
  endfunction

  function automatic logic [31:0] win(input int a, input int b);
    logic [31:0] m = '0;
    for (int t = a; t <= b; t++) m[t] = 1'b1;
    return m;
  endfunction

  task automatic set_all(input logic [31:0] m);
    for (int k = 0; k < 8; k++) pass_map[k] = m;
  endtask

  // PHY model: acks each request and returns the DLP burst; failing lanes
  // carry one flipped bit at a tap-dependent sample position.
  initial begin : phy
    int cur;
    int nsamp;
    logic [7:0] dq;
    rd_ack_i = 1'b0;
    samp_valid_i = 1'b0;
    samp_dq_i = '0;
    forever begin
      @(negedge mem_clk);
      if (rd_req_o && mem_rst_n) begin
        rd_ack_i = 1'b1;
        cur = int'(sweep_tap_o);
        ack_cnt++;
        @(negedge mem_clk);
        rd_ack_i = 1'b0;
        in_burst = 1'b1;
        nsamp = (cur == to_tap) ? 3 : 16;
        for (int n = 0; n < nsamp; n++) begin
          if (n == 8) begin
            samp_valid_i = 1'b0;
            @(negedge mem_clk);
          end
          for (int k = 0; k < 8; k++) begin
            dq[k] = pattern[7 - (n % 8)];
            if (!pass_map[k][cur] && (n == cur % 16)) dq[k] = ~dq[k];
          end
          samp_valid_i = 1'b1;
          samp_dq_i = dq;
          @(negedge mem_clk);
        end
        samp_valid_i = 1'b0;
        in_burst = 1'b0;
      end
    end
  end

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge mem_clk);
      if (mem_rst_n && cal_done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("lane_tap", 64'(lane_tap_o), 64'(e.taps));
          chk("lane_fail", 64'(lane_fail_o), 64'(e.fail));
          chk("timeout", 64'(timeout_o), 64'(e.to));
          chk("busy_at_done", 64'(cal_busy_o), 64'd0);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge mem_clk);
    cal_start_i = 1'b1;
    @(negedge mem_clk);
    cal_start_i = 1'b0;
  endtask

  task automatic wait_sb_empty();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge mem_clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_wait_expired", 64'd1, 64'd0);
      sb.delete();
    end
  endtask

  task automatic run_cal(input logic [39:0] taps, input logic [7:0] fail, input logic to);
    exp_t e;
    e.taps = taps;
    e.fail = fail;
    e.to = to;
    sb.push_back(e);
    ack_cnt = 0;
    pulse_start();
    wait_sb_empty();
  endtask

  task automatic wait_tap(input int t, input logic need_burst);
    int n = 0;
    while (!((int'(sweep_tap_o) == t) && (in_burst || !need_burst)) && n < 3000) begin
      @(negedge mem_clk);
      n++;
    end
    if (n >= 3000) chk("wait_tap_expired", 64'd1, 64'd0);
  endtask

  initial begin : stim
    logic [39:0] t;
    mem_rst_n = 1'b0;
    cal_start_i = 1'b0;
    cal_abort_i = 1'b0;
    set_all('0);
    repeat (3) @(negedge mem_clk);
    chk("rst_rd_req", 64'(rd_req_o), 64'd0);
    chk("rst_busy", 64'(cal_busy_o), 64'd0);
    chk("rst_done", 64'(cal_done_o), 64'd0);
    chk("rst_sweep_tap", 64'(sweep_tap_o), 64'd0);
    chk("rst_lane_tap", 64'(lane_tap_o), 64'd0);
    chk("rst_lane_fail", 64'(lane_fail_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    mem_rst_n = 1'b1;
    repeat (2) @(negedge mem_clk);

    // Window 10..20 on every lane -> centre 15.
    set_all(win(10, 20));
    run_cal(rep(15), 8'h00, 1'b0);
    chk("sweep_count_1", 64'(ack_cnt), 64'd32);

    // Lane 3: windows 2..4 and 20..27 (wider wins) -> 23; others 5..9 -> 7.
    set_all(win(5, 9));
    pass_map[3] = win(2, 4) | win(20, 27);
    t = rep(7);
    t[3*5 +: 5] = 5'd23;
    run_cal(t, 8'h00, 1'b0);

    // Lane 5 never passes, lane 6 window too short -> both fail, tap 0.
    set_all(win(5, 9));
    pass_map[5] = '0;
    pass_map[6] = win(0, 1);
    t = rep(7);
    t[5*5 +: 5] = 5'd0;
    t[6*5 +: 5] = 5'd0;
    run_cal(t, 8'h60, 1'b0);

    // Burst stalls at tap 12: tap forced failing, window 0..11 -> 5.
    set_all(win(0, 12));
    to_tap = 12;
    run_cal(rep(5), 8'h00, 1'b1);
    to_tap = -1;

    // All taps pass, window reaches TAP_MAX; a second start while busy is ignored.
    set_all('1);
    begin
      exp_t e;
      e.taps = rep(15);
      e.fail = 8'h00;
      e.to = 1'b0;
      sb.push_back(e);
      ack_cnt = 0;
      pulse_start();
      repeat (60) @(negedge mem_clk);
      pulse_start();
      wait_sb_empty();
      chk("sweep_count_restart", 64'(ack_cnt), 64'd32);
    end

    // Start and abort together in IDLE: abort wins.
    @(negedge mem_clk);
    cal_start_i = 1'b1;
    cal_abort_i = 1'b1;
    @(negedge mem_clk);
    cal_start_i = 1'b0;
    cal_abort_i = 1'b0;
    chk("start_abort_busy", 64'(cal_busy_o), 64'd0);
    repeat (8) @(negedge mem_clk);
    chk("start_abort_req", 64'(rd_req_o), 64'd0);

    // Abort during CAPTURE at tap 7.
    pulse_start();
    wait_tap(7, 1'b1);
    cal_abort_i = 1'b1;
    @(negedge mem_clk);
    cal_abort_i = 1'b0;
    chk("abort_rd_req", 64'(rd_req_o), 64'd0);
    chk("abort_busy", 64'(cal_busy_o), 64'd0);
    chk("abort_lane_tap", 64'(lane_tap_o), 64'(rep(15)));
    chk("abort_lane_fail", 64'(lane_fail_o), 64'd0);
    repeat (40) @(negedge mem_clk);
    chk("abort_busy_later", 64'(cal_busy_o), 64'd0);

    // Asynchronous reset mid-sweep, applied between clock edges.
    pulse_start();
    wait_tap(20, 1'b0);
    #2;
    mem_rst_n = 1'b0;
    #1;
    chk("arst_rd_req", 64'(rd_req_o), 64'd0);
    chk("arst_busy", 64'(cal_busy_o), 64'd0);
    chk("arst_sweep_tap", 64'(sweep_tap_o), 64'd0);
    chk("arst_lane_tap", 64'(lane_tap_o), 64'd0);
    chk("arst_lane_fail", 64'(lane_fail_o), 64'd0);
    chk("arst_timeout", 64'(timeout_o), 64'd0);
    chk("arst_done", 64'(cal_done_o), 64'd0);
    repeat (3) @(negedge mem_clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
